// File: rtl/mfcc_pkg.sv
// Shared defaults and elaboration-time helpers for the MFCC front end.
// The Hamming table is built from a Taylor-series sine so it folds to constants.
package mfcc_pkg;

  localparam int WIN_FRAME_LEN = 80;
  localparam int WIN_SAMPLE_W  = 16;
  localparam int WIN_COEF_W    = 12;

  function automatic int win_half(input int frame_len);
    return (frame_len + 1) / 2;
  endfunction

  // Accurate to ~1e-11 over [-pi/2, pi/2], which is all the ROM ever needs.
  function automatic real win_sin_taylor(input real y);
    real y2;
    real term;
    real acc;
    y2   = y * y;
    term = y;
    acc  = y;
    for (int i = 1; i < 9; i++) begin
      term = -term * y2 / real'((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic int win_hamming_coef(input int k, input int frame_len, input int coef_w);
    real pi_r;
    real x;
    real w;
    real full;
    pi_r = 3.14159265358979323846;
    x    = 2.0 * pi_r * real'(k) / real'(frame_len - 1);
    // cos(x) == -sin(x - pi/2); x never exceeds pi for k < HALF
    w    = 0.54 + 0.46 * win_sin_taylor(x - pi_r / 2.0);
    full = real'((1 << coef_w) - 1);
    return $rtoi(w * full + 0.5);
  endfunction

endpackage

// File: rtl/mfcc_win_coef_rom.sv
// Half-length Hamming coefficient ROM with a registered, enable-gated read port.
module mfcc_win_coef_rom
  import mfcc_pkg::*;
#(
  parameter  int FRAME_LEN = WIN_FRAME_LEN,
  parameter  int COEF_W    = WIN_COEF_W,
  localparam int HALF      = win_half(FRAME_LEN),
  localparam int ADDR_W    = $clog2(HALF)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [COEF_W-1:0] o_coef
);

  logic [COEF_W-1:0] w_rom [HALF];
  logic [COEF_W-1:0] r_coef;

  for (genvar k = 0; k < HALF; k++) begin : g_rom
    localparam int C = win_hamming_coef(k, FRAME_LEN, COEF_W);
    assign w_rom[k] = COEF_W'(C);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_coef <= '0;
    end else if (i_en) begin
      r_coef <= w_rom[i_addr];
    end
  end

  assign o_coef = r_coef;

endmodule

// File: rtl/mfcc_window_unit.sv
// Streaming window multiply between framer and FFT.
// Pipeline: S1 ROM read + sample register, S2 multiply, S3 round to output.
module mfcc_window_unit
  import mfcc_pkg::*;
#(
  parameter int FRAME_LEN = WIN_FRAME_LEN,
  parameter int SAMPLE_W  = WIN_SAMPLE_W,
  parameter int COEF_W    = WIN_COEF_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_win_bypass,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  input  logic                       i_s_sof,
  input  logic signed [SAMPLE_W-1:0] i_s_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic signed [SAMPLE_W-1:0] o_m_data,
  output logic                       o_m_last,
  output logic                       o_frame_err
);

  localparam int HALF   = win_half(FRAME_LEN);
  localparam int ADDR_W = $clog2(HALF);
  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int PROD_W = SAMPLE_W + COEF_W + 1;
  localparam logic [IDX_W-1:0]         IDX_LAST   = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]         IDX_HALF   = IDX_W'(HALF);
  localparam logic [COEF_W-1:0]        COEF_ONE   = '1;
  localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1) << (COEF_W - 1);

  logic [IDX_W-1:0]           r_idx;
  logic                       r_s1_valid;
  logic                       r_s1_last;
  logic                       r_s1_bypass;
  logic signed [SAMPLE_W-1:0] r_s1_data;
  logic                       r_s2_valid;
  logic                       r_s2_last;
  logic signed [PROD_W-1:0]   r_s2_prod;
  logic                       r_m_valid;
  logic                       r_m_last;
  logic signed [SAMPLE_W-1:0] r_m_data;
  logic                       r_frame_err;

  logic                       w_stall;
  logic                       w_en1;
  logic                       w_en2;
  logic                       w_en3;
  logic                       w_accept;
  logic [IDX_W-1:0]           w_idx_use;
  logic [IDX_W-1:0]           w_idx_next;
  logic [ADDR_W-1:0]          w_rom_addr;
  logic [COEF_W-1:0]          w_rom_coef;
  logic [COEF_W-1:0]          w_coef;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [PROD_W-1:0]   w_round;
  logic                       w_unused_round;

  // A stage may load whenever the stage after it moves or it holds a bubble.
  assign w_stall    = r_m_valid & ~i_m_ready;
  assign w_en3      = ~w_stall;
  assign w_en2      = w_en3 | ~r_s2_valid;
  assign w_en1      = w_en2 | ~r_s1_valid;
  assign w_accept   = i_s_valid & ~w_stall;
  assign w_idx_use  = i_s_sof ? '0 : r_idx;
  assign w_idx_next = (w_idx_use == IDX_LAST) ? '0 : w_idx_use + IDX_W'(1);

  always_comb begin
    w_rom_addr = '0;
    if (w_idx_use < IDX_HALF) begin
      w_rom_addr = ADDR_W'(w_idx_use);
    end else begin
      w_rom_addr = ADDR_W'(IDX_LAST - w_idx_use);
    end
  end

  mfcc_win_coef_rom #(
    .FRAME_LEN (FRAME_LEN),
    .COEF_W    (COEF_W)
  ) u_rom (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (~w_stall),
    .i_addr (w_rom_addr),
    .o_coef (w_rom_coef)
  );

  always_comb begin
    w_coef = w_rom_coef;
    if (r_s1_bypass) begin
      w_coef = COEF_ONE;
    end else begin
      w_coef = w_rom_coef;
    end
  end

  assign w_prod  = PROD_W'(r_s1_data) * PROD_W'($signed({1'b0, w_coef}));
  assign w_round = r_s2_prod + ROUND_HALF;
  assign w_unused_round = ^{w_round[PROD_W-1], w_round[COEF_W-1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_frame_err <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_bypass <= 1'b0;
      r_s1_data   <= '0;
    end else begin
      r_frame_err <= w_accept & i_s_sof & (r_idx != '0);
      if (w_accept) begin
        r_idx <= w_idx_next;
      end
      if (w_en1) begin
        r_s1_valid  <= w_accept;
        r_s1_last   <= w_idx_use == IDX_LAST;
        r_s1_bypass <= i_win_bypass;
        r_s1_data   <= i_s_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_prod  <= '0;
    end else if (w_en2) begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_prod  <= w_prod;
    end
  end

  // Arithmetic shift of the biased product: round half toward +inf.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_en3) begin
      r_m_valid <= r_s2_valid;
      r_m_last  <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        r_m_data <= w_round[COEF_W +: SAMPLE_W];
      end
    end
  end

  assign o_s_ready   = ~w_stall;
  assign o_m_valid   = r_m_valid;
  assign o_m_data    = r_m_data;
  assign o_m_last    = r_m_last;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_mfcc_window_unit.sv
// Bench for mfcc_window_unit: an 80-sample and an 81-sample instance checked
// every cycle against a floating-point Hamming model plus literal anchors.
module tb_mfcc_window_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              s_valid [2];
  logic              s_sof   [2];
  logic              byp     [2];
  logic              m_ready [2];
  logic signed [15:0] s_data [2];
  logic              s_ready [2];
  logic              m_valid [2];
  logic              m_last  [2];
  logic              ferr    [2];
  logic signed [15:0] m_data [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit rnd       [2];
  bit lat_arm   [2];
  bit lat_wait  [2];
  int lat_t0    [2];
  int pend      [2];
  int ferr_seen [2];
  int log_n     [2];
  int log_d     [2][128];
  bit log_l     [2][128];

  mfcc_window_unit #(.FRAME_LEN(80), .SAMPLE_W(16), .COEF_W(12)) dut80 (
    .i_clk(clk), .i_rst(rst), .i_win_bypass(byp[0]), .i_s_valid(s_valid[0]),
    .o_s_ready(s_ready[0]), .i_s_sof(s_sof[0]), .i_s_data(s_data[0]),
    .o_m_valid(m_valid[0]), .i_m_ready(m_ready[0]), .o_m_data(m_data[0]),
    .o_m_last(m_last[0]), .o_frame_err(ferr[0]));

  mfcc_window_unit #(.FRAME_LEN(81), .SAMPLE_W(16), .COEF_W(12)) dut81 (
    .i_clk(clk), .i_rst(rst), .i_win_bypass(byp[1]), .i_s_valid(s_valid[1]),
    .o_s_ready(s_ready[1]), .i_s_sof(s_sof[1]), .i_s_data(s_data[1]),
    .o_m_valid(m_valid[1]), .i_m_ready(m_ready[1]), .o_m_data(m_data[1]),
    .o_m_last(m_last[1]), .o_frame_err(ferr[1]));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int model_coef(input int n, input int len);
    int  k;
    real w;
    k = (n < (len + 1) / 2) ? n : len - 1 - n;
    w = 0.54 - 0.46 * $cos(2.0 * 3.14159265358979323846 * k / (len - 1));
    return $rtoi(w * 4095.0 + 0.5);
  endfunction

  function automatic int model_out(input int s, input int n, input int len, input bit bypass);
    longint c;
    longint p;
    c = bypass ? 64'sd4095 : longint'(model_coef(n, len));
    p = longint'(s) * c + 64'sd2048;
    return int'(p >>> 12);
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #2;
    for (int u = 0; u < 2; u++) m_ready[u] = rnd[u] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int N = (g == 0) ? 80 : 81;
    int qd[$];
    bit ql[$];
    int midx = 0;
    bit ferr_exp = 0;
    bit held = 0;
    int hold_d = 0;
    bit hold_l = 0;
    int use_idx;
    always @(negedge clk) begin
      if (rst) begin
        qd.delete(); ql.delete();
        midx = 0; ferr_exp = 0; held = 0; pend[g] = 0;
      end else begin
        chk("frame_err", int'(ferr[g]), int'(ferr_exp));
        if (ferr[g]) ferr_seen[g]++;
        chk("s_ready", int'(s_ready[g]), int'(!(m_valid[g] && !m_ready[g])));
        if (held) begin
          chk("hold_valid", int'(m_valid[g]), 1);
          chk("hold_data", int'(m_data[g]), hold_d);
          chk("hold_last", int'(m_last[g]), int'(hold_l));
        end
        if (lat_wait[g] && m_valid[g]) begin
          chk("latency", cyc - lat_t0[g], 3);
          lat_wait[g] = 0;
        end
        if (m_valid[g]) begin
          chk("out_pending", int'(qd.size() > 0), 1);
          if (m_ready[g] && qd.size() > 0) begin
            chk("m_data", int'(m_data[g]), qd[0]);
            chk("m_last", int'(m_last[g]), int'(ql[0]));
            if (log_n[g] < 128) begin
              log_d[g][log_n[g]] = int'(m_data[g]);
              log_l[g][log_n[g]] = m_last[g];
            end
            log_n[g]++;
            void'(qd.pop_front());
            void'(ql.pop_front());
          end
        end
        held   = m_valid[g] && !m_ready[g];
        hold_d = int'(m_data[g]);
        hold_l = m_last[g];
        ferr_exp = 0;
        if (s_valid[g] && s_ready[g]) begin
          use_idx = s_sof[g] ? 0 : midx;
          if (s_sof[g] && midx != 0) ferr_exp = 1;
          qd.push_back(model_out(int'(s_data[g]), use_idx, N, byp[g]));
          ql.push_back(use_idx == N - 1);
          midx = (use_idx == N - 1) ? 0 : use_idx + 1;
          if (lat_arm[g]) begin
            lat_arm[g] = 0; lat_wait[g] = 1; lat_t0[g] = cyc;
          end
        end
        pend[g] = qd.size();
      end
    end
  end

  task automatic send(input int u, input logic signed [15:0] d, input logic sof, input logic bp);
    int guard;
    guard = 0;
    s_valid[u] = 1'b1; s_data[u] = d; s_sof[u] = sof; byp[u] = bp;
    do begin
      @(negedge clk);
      guard++;
    end while (!s_ready[u] && guard < 1000);
    chk("send_ready", int'(s_ready[u]), 1);
    @(posedge clk);
    #2;
    s_valid[u] = 1'b0; s_sof[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    int guard;
    guard = 0;
    while (pend[u] != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", pend[u], 0);
    @(posedge clk);
    #2;
  endtask

  task automatic count_last(input int u, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) cnt += int'(log_l[u][i]);
  endtask

  task automatic rst_in_flight(input int u, input int len);
    int lc;
    send(u, 16'sd1234, 1'b0, 1'b0);
    send(u, 16'sd2345, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("t6_pre_valid", int'(m_valid[u]), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(m_valid[u]), 0);
    chk("t6_rst_data", int'(m_data[u]), 0);
    chk("t6_rst_last", int'(m_last[u]), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    log_n[u] = 0;
    for (int i = 0; i < len; i++) send(u, 16'sd16384, 1'b0, 1'b0);
    drain(u);
    chk("t6_count", log_n[u], len);
    chk("t6_first", log_d[u][0], 1312);
    chk("t6_last_pos", int'(log_l[u][len-1]), 1);
    count_last(u, len, lc);
    chk("t6_last_cnt", lc, 1);
  endtask

  initial begin
    int lc;
    int fs;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      s_valid[u] = 1'b0; s_sof[u] = 1'b0; byp[u] = 1'b0; m_ready[u] = 1'b1;
      s_data[u] = '0; rnd[u] = 0; lat_arm[u] = 0; lat_wait[u] = 0; lat_t0[u] = 0;
      pend[u] = 0; ferr_seen[u] = 0; log_n[u] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int u = 0; u < 2; u++) begin
      chk("rst_m_valid", int'(m_valid[u]), 0);
      chk("rst_m_data", int'(m_data[u]), 0);
      chk("rst_m_last", int'(m_last[u]), 0);
      chk("rst_frame_err", int'(ferr[u]), 0);
      chk("rst_s_ready", int'(s_ready[u]), 1);
    end
    rst = 1'b0;

    // 1: constant 16384 frame, latency and last tagging
    lat_arm[0] = 1; log_n[0] = 0;
    for (int i = 0; i < 80; i++) send(0, 16'sd16384, i == 0, 1'b0);
    drain(0);
    chk("t1_latency_seen", int'(lat_wait[0]), 0);
    chk("t1_count", log_n[0], 80);
    chk("t1_out0", log_d[0][0], 1312);
    chk("t1_out79", log_d[0][79], 1312);
    chk("t1_last79", int'(log_l[0][79]), 1);
    count_last(0, 80, lc);
    chk("t1_last_cnt", lc, 1);

    // 2: negative frame and symmetry
    log_n[0] = 0;
    for (int i = 0; i < 80; i++) send(0, -16'sd16384, i == 0, 1'b0);
    drain(0);
    chk("t2_out0", log_d[0][0], -1312);
    for (int k = 0; k < 40; k++) chk("t2_sym", log_d[0][k], log_d[0][79-k]);

    // 3: bypass
    log_n[0] = 0;
    send(0, 16'sd1000, 1'b1, 1'b1);
    send(0, -16'sd1, 1'b0, 1'b1);
    send(0, 16'sd32767, 1'b0, 1'b1);
    drain(0);
    chk("t3_byp_1000", log_d[0][0], 1000);
    chk("t3_byp_m1", log_d[0][1], -1);
    chk("t3_byp_max", log_d[0][2], 32759);

    // 4: random backpressure over 3 frames
    rnd[0] = 1; log_n[0] = 0;
    for (int i = 0; i < 240; i++) send(0, 16'($urandom), 1'b0, 1'b0);
    drain(0);
    rnd[0] = 0;
    chk("t4_count", log_n[0], 240);

    // 5: short frame (index now 3), resync at index 37
    for (int i = 0; i < 34; i++) send(0, 16'sd500, 1'b0, 1'b0);
    drain(0);
    fs = ferr_seen[0]; log_n[0] = 0;
    send(0, 16'sd16384, 1'b1, 1'b0);
    for (int i = 0; i < 79; i++) send(0, 16'sd16384, 1'b0, 1'b0);
    drain(0);
    chk("t5_ferr_pulses", ferr_seen[0] - fs, 1);
    chk("t5_first", log_d[0][0], 1312);
    chk("t5_last79", int'(log_l[0][79]), 1);
    count_last(0, 80, lc);
    chk("t5_last_cnt", lc, 1);

    // 6: reset with samples in flight, both frame lengths
    rst_in_flight(0, 80);
    rst_in_flight(1, 81);
    chk("t6_81_centre", log_d[1][40], 16380);
    for (int k = 0; k < 40; k++) chk("t6_81_sym", log_d[1][k], log_d[1][80-k]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
